// File: rtl/rs_pkg.sv
// rs_pkg
// Shared definitions for the integer reservation station: default field
// widths, the entry record layout and the CDB tag-compare helper.
// No ports (package).
package rs_pkg;

    localparam int ROB_ADDR_WIDTH_DEF = 4;
    localparam int OPGEN_WIDTH_DEF    = 6;
    localparam int SHAMT_WIDTH_DEF    = 5;
    localparam int DATA_WIDTH_DEF     = 32;

    // Widest tag the compare helper handles; narrower tags are zero-extended
    // so one helper serves every ROB_ADDR_WIDTH up to this size.
    localparam int TAG_MAX_WIDTH      = 16;

    typedef struct packed {
        logic                          valid;
        logic [ROB_ADDR_WIDTH_DEF-1:0] rob_addr;
        logic [OPGEN_WIDTH_DEF-1:0]    opgen;
        logic [SHAMT_WIDTH_DEF-1:0]    shamt;
        logic [1:0]                    is_ref;
        logic [DATA_WIDTH_DEF-1:0]     data_1;
        logic [DATA_WIDTH_DEF-1:0]     data_2;
    } rs_entry_t;

    // True when a broadcast port is enabled and carries the tag being waited on.
    function automatic logic TAG_MATCH(input logic                     en,
                                       input logic [TAG_MAX_WIDTH-1:0] ref_tag,
                                       input logic [TAG_MAX_WIDTH-1:0] bus_tag);
        return en && (ref_tag == bus_tag);
    endfunction

endpackage

// File: rtl/rs_int_entry.sv
// rs_int_entry
// One reservation-station line: field storage, CDB wakeup across all ports,
// same-cycle write bypass and the ready flag.
// Ports:
//   clk, rst (sync, active-low), flush  - clock / reset / discard
//   wr_en + wr_* fields                 - load this line (only when invalid)
//   cdb_en / cdb_tag / cdb_data         - flattened broadcast ports
//   iss_clr                             - this line was issued, free it
//   valid, ready, rob_addr .. data_2    - registered line contents
module rs_int_entry
    import rs_pkg::*;
#(
    parameter int CDB_PORTS      = 2,
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int OPGEN_WIDTH    = OPGEN_WIDTH_DEF,
    parameter int SHAMT_WIDTH    = SHAMT_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                wr_en,
    input  logic [ROB_ADDR_WIDTH-1:0]           wr_rob_addr,
    input  logic [OPGEN_WIDTH-1:0]              wr_opgen,
    input  logic [SHAMT_WIDTH-1:0]              wr_shamt,
    input  logic [1:0]                          wr_is_ref,
    input  logic [DATA_WIDTH-1:0]               wr_data_1,
    input  logic [DATA_WIDTH-1:0]               wr_data_2,
    input  logic [CDB_PORTS-1:0]                cdb_en,
    input  logic [CDB_PORTS*ROB_ADDR_WIDTH-1:0] cdb_tag,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0]     cdb_data,
    input  logic                                iss_clr,
    output logic                                valid,
    output logic                                ready,
    output logic [ROB_ADDR_WIDTH-1:0]           rob_addr,
    output logic [OPGEN_WIDTH-1:0]              opgen,
    output logic [SHAMT_WIDTH-1:0]              shamt,
    output logic [DATA_WIDTH-1:0]               data_1,
    output logic [DATA_WIDTH-1:0]               data_2
);

    logic [1:0]                is_ref;

    // Four tag probes: 0/1 are the incoming operands (bypass), 2/3 the stored ones (wakeup).
    logic [ROB_ADDR_WIDTH-1:0] probe    [4];
    logic [3:0]                hit;
    logic [DATA_WIDTH-1:0]     hit_data [4];

    assign probe[0] = wr_data_1[ROB_ADDR_WIDTH-1:0];
    assign probe[1] = wr_data_2[ROB_ADDR_WIDTH-1:0];
    assign probe[2] = data_1[ROB_ADDR_WIDTH-1:0];
    assign probe[3] = data_2[ROB_ADDR_WIDTH-1:0];

    // Scan ports from high to low so the lowest matching port is the one left standing.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            hit[k]      = 1'b0;
            hit_data[k] = '0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (TAG_MATCH(cdb_en[p], TAG_MAX_WIDTH'(probe[k]),
                              TAG_MAX_WIDTH'(cdb_tag[p*ROB_ADDR_WIDTH +: ROB_ADDR_WIDTH]))) begin
                    hit[k]      = 1'b1;
                    hit_data[k] = cdb_data[p*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Write and issue never target the same line in one cycle: writes go to
    // invalid lines, issue only picks valid ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid    <= 1'b0;
            rob_addr <= '0;
            opgen    <= '0;
            shamt    <= '0;
            is_ref   <= '0;
            data_1   <= '0;
            data_2   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr_en) begin
            valid    <= 1'b1;
            rob_addr <= wr_rob_addr;
            opgen    <= wr_opgen;
            shamt    <= wr_shamt;
            if (wr_is_ref[0] && hit[0]) begin
                data_1    <= hit_data[0];
                is_ref[0] <= 1'b0;
            end else begin
                data_1    <= wr_data_1;
                is_ref[0] <= wr_is_ref[0];
            end
            if (wr_is_ref[1] && hit[1]) begin
                data_2    <= hit_data[1];
                is_ref[1] <= 1'b0;
            end else begin
                data_2    <= wr_data_2;
                is_ref[1] <= wr_is_ref[1];
            end
        end else begin
            if (iss_clr) begin
                valid <= 1'b0;
            end
            if (valid && is_ref[0] && hit[2]) begin
                data_1    <= hit_data[2];
                is_ref[0] <= 1'b0;
            end
            if (valid && is_ref[1] && hit[3]) begin
                data_2    <= hit_data[3];
                is_ref[1] <= 1'b0;
            end
        end
    end

    assign ready = valid && !is_ref[0] && !is_ref[1];

endmodule

// File: rtl/rs_int_queue.sv
// rs_int_queue
// Multi-line integer reservation station between dispatch and the ALU.
// Ports:
//   clk, rst (sync, active-low), flush
//   wr_valid/wr_ready + wr_* fields  - dispatch handshake
//   cdb_en/cdb_tag/cdb_data          - flattened CDB broadcast ports
//   iss_valid/iss_ready + iss_*      - issue handshake, lowest ready line
//   count                            - number of occupied lines
module rs_int_queue
    import rs_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int CDB_PORTS      = 2,
    parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF,
    parameter int OPGEN_WIDTH    = OPGEN_WIDTH_DEF,
    parameter int SHAMT_WIDTH    = SHAMT_WIDTH_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                flush,
    input  logic                                wr_valid,
    output logic                                wr_ready,
    input  logic [ROB_ADDR_WIDTH-1:0]           wr_rob_addr,
    input  logic [OPGEN_WIDTH-1:0]              wr_opgen,
    input  logic [SHAMT_WIDTH-1:0]              wr_shamt,
    input  logic [1:0]                          wr_is_ref,
    input  logic [DATA_WIDTH-1:0]               wr_data_1,
    input  logic [DATA_WIDTH-1:0]               wr_data_2,
    input  logic [CDB_PORTS-1:0]                cdb_en,
    input  logic [CDB_PORTS*ROB_ADDR_WIDTH-1:0] cdb_tag,
    input  logic [CDB_PORTS*DATA_WIDTH-1:0]     cdb_data,
    output logic                                iss_valid,
    input  logic                                iss_ready,
    output logic [ROB_ADDR_WIDTH-1:0]           iss_rob_addr,
    output logic [OPGEN_WIDTH-1:0]              iss_opgen,
    output logic [SHAMT_WIDTH-1:0]              iss_shamt,
    output logic [DATA_WIDTH-1:0]               iss_data_1,
    output logic [DATA_WIDTH-1:0]               iss_data_2,
    output logic [$clog2(DEPTH+1)-1:0]          count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [DEPTH-1:0]          ent_valid;
    logic [DEPTH-1:0]          ent_ready;
    logic [ROB_ADDR_WIDTH-1:0] ent_rob   [DEPTH];
    logic [OPGEN_WIDTH-1:0]    ent_opgen [DEPTH];
    logic [SHAMT_WIDTH-1:0]    ent_shamt [DEPTH];
    logic [DATA_WIDTH-1:0]     ent_d1    [DEPTH];
    logic [DATA_WIDTH-1:0]     ent_d2    [DEPTH];

    logic [IW-1:0]             alloc_idx;
    logic [IW-1:0]             sel_idx;
    logic                      wr_fire;
    logic                      iss_fire;

    // Last presented issue fields, shown while nothing is ready.
    logic [ROB_ADDR_WIDTH-1:0] hold_rob;
    logic [OPGEN_WIDTH-1:0]    hold_opgen;
    logic [SHAMT_WIDTH-1:0]    hold_shamt;
    logic [DATA_WIDTH-1:0]     hold_d1;
    logic [DATA_WIDTH-1:0]     hold_d2;

    // Both handshake qualifiers depend only on registered state.
    assign wr_ready  = (count != CW'(DEPTH));
    assign iss_valid = |ent_ready;

    // Flush swallows any write or issue offered in the same cycle.
    assign wr_fire  = wr_valid && wr_ready && !flush;
    assign iss_fire = iss_valid && iss_ready && !flush;

    // Lowest free line; a line freed by issue this cycle still reads valid,
    // so it only becomes allocatable next cycle.
    always_comb begin
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                alloc_idx = IW'(i);
            end
        end
    end

    // Lowest ready line drives the issue port.
    always_comb begin
        sel_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ent_ready[i]) begin
                sel_idx = IW'(i);
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_int_entry #(
            .CDB_PORTS      (CDB_PORTS),
            .ROB_ADDR_WIDTH (ROB_ADDR_WIDTH),
            .OPGEN_WIDTH    (OPGEN_WIDTH),
            .SHAMT_WIDTH    (SHAMT_WIDTH),
            .DATA_WIDTH     (DATA_WIDTH)
        ) u_entry (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .wr_en       (wr_fire && (alloc_idx == IW'(g))),
            .wr_rob_addr (wr_rob_addr),
            .wr_opgen    (wr_opgen),
            .wr_shamt    (wr_shamt),
            .wr_is_ref   (wr_is_ref),
            .wr_data_1   (wr_data_1),
            .wr_data_2   (wr_data_2),
            .cdb_en      (cdb_en),
            .cdb_tag     (cdb_tag),
            .cdb_data    (cdb_data),
            .iss_clr     (iss_fire && (sel_idx == IW'(g))),
            .valid       (ent_valid[g]),
            .ready       (ent_ready[g]),
            .rob_addr    (ent_rob[g]),
            .opgen       (ent_opgen[g]),
            .shamt       (ent_shamt[g]),
            .data_1      (ent_d1[g]),
            .data_2      (ent_d2[g])
        );
    end

    assign iss_rob_addr = iss_valid ? ent_rob[sel_idx]   : hold_rob;
    assign iss_opgen    = iss_valid ? ent_opgen[sel_idx] : hold_opgen;
    assign iss_shamt    = iss_valid ? ent_shamt[sel_idx] : hold_shamt;
    assign iss_data_1   = iss_valid ? ent_d1[sel_idx]    : hold_d1;
    assign iss_data_2   = iss_valid ? ent_d2[sel_idx]    : hold_d2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_rob   <= '0;
            hold_opgen <= '0;
            hold_shamt <= '0;
            hold_d1    <= '0;
            hold_d2    <= '0;
        end else if (iss_valid) begin
            hold_rob   <= ent_rob[sel_idx];
            hold_opgen <= ent_opgen[sel_idx];
            hold_shamt <= ent_shamt[sel_idx];
            hold_d1    <= ent_d1[sel_idx];
            hold_d2    <= ent_d2[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            count <= '0;
        end else begin
            case ({wr_fire, iss_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_int_queue.sv
// tb_rs_int_queue
// Self-checking bench for rs_int_queue (default parameters). Expected issue
// records are queued when their writes are driven and compared in order as
// the issue handshakes happen. Inputs change on the falling edge; status is
// checked on the falling edge after each rising edge.
module tb_rs_int_queue;
    import rs_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_rob_addr;
    logic [5:0]  wr_opgen;
    logic [4:0]  wr_shamt;
    logic [1:0]  wr_is_ref;
    logic [31:0] wr_data_1;
    logic [31:0] wr_data_2;
    logic [1:0]  cdb_en;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        iss_valid;
    logic        iss_ready;
    logic [3:0]  iss_rob_addr;
    logic [5:0]  iss_opgen;
    logic [4:0]  iss_shamt;
    logic [31:0] iss_data_1;
    logic [31:0] iss_data_2;
    logic [2:0]  count;

    int assertCount = 0;
    int failCount   = 0;

    rs_entry_t sb[$];

    rs_int_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_rob_addr  (wr_rob_addr),
        .wr_opgen     (wr_opgen),
        .wr_shamt     (wr_shamt),
        .wr_is_ref    (wr_is_ref),
        .wr_data_1    (wr_data_1),
        .wr_data_2    (wr_data_2),
        .cdb_en       (cdb_en),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_rob_addr (iss_rob_addr),
        .iss_opgen    (iss_opgen),
        .iss_shamt    (iss_shamt),
        .iss_data_1   (iss_data_1),
        .iss_data_2   (iss_data_2),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_valid = 1'b0;
        cdb_en   = '0;
        flush    = 1'b0;
    endtask

    task automatic applyStimulus(input logic [3:0] rob, input logic [5:0] opgen,
                                 input logic [4:0] shamt, input logic [1:0] is_ref,
                                 input logic [31:0] d1, input logic [31:0] d2);
        wr_valid    = 1'b1;
        wr_rob_addr = rob;
        wr_opgen    = opgen;
        wr_shamt    = shamt;
        wr_is_ref   = is_ref;
        wr_data_1   = d1;
        wr_data_2   = d2;
    endtask

    task automatic setCdb(input int p, input logic [3:0] tag, input logic [31:0] data);
        cdb_en[p]           = 1'b1;
        cdb_tag[p*4 +: 4]   = tag;
        cdb_data[p*32 +: 32] = data;
    endtask

    task automatic pushExp(input logic [3:0] rob, input logic [5:0] opgen,
                           input logic [4:0] shamt, input logic [31:0] d1,
                           input logic [31:0] d2);
        rs_entry_t e;
        e.valid    = 1'b1;
        e.rob_addr = rob;
        e.opgen    = opgen;
        e.shamt    = shamt;
        e.is_ref   = 2'b00;
        e.data_1   = d1;
        e.data_2   = d2;
        sb.push_back(e);
    endtask

    // Issue monitor: sampled late in the low phase, just before the rising edge.
    always @(negedge clk) begin
        #4;
        if (rst && !flush && iss_valid && iss_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                rs_entry_t e;
                e = sb.pop_front();
                checkOutput("iss_rob_addr", 32'(iss_rob_addr), 32'(e.rob_addr));
                checkOutput("iss_opgen",    32'(iss_opgen),    32'(e.opgen));
                checkOutput("iss_shamt",    32'(iss_shamt),    32'(e.shamt));
                checkOutput("iss_data_1",   iss_data_1,        e.data_1);
                checkOutput("iss_data_2",   iss_data_2,        e.data_2);
            end
        end
    end

    initial begin
        rst         = 1'b0;
        iss_ready   = 1'b0;
        wr_rob_addr = '0;
        wr_opgen    = '0;
        wr_shamt    = '0;
        wr_is_ref   = '0;
        wr_data_1   = '0;
        wr_data_2   = '0;
        cdb_tag     = '0;
        cdb_data    = '0;
        idle();

        // Reset state
        tick();
        tick();
        checkOutput("rst_wr_ready",  32'(wr_ready),     32'd1);
        checkOutput("rst_iss_valid", 32'(iss_valid),    32'd0);
        checkOutput("rst_count",     32'(count),        32'd0);
        checkOutput("rst_iss_rob",   32'(iss_rob_addr), 32'd0);
        checkOutput("rst_iss_d1",    iss_data_1,        32'd0);
        rst = 1'b1;
        tick();

        // Plain write then issue
        applyStimulus(4'd3, 6'd5, 5'd1, 2'b00, 32'd10, 32'd20);
        pushExp(4'd3, 6'd5, 5'd1, 32'd10, 32'd20);
        tick();
        idle();
        checkOutput("wr_iss_valid", 32'(iss_valid),    32'd1);
        checkOutput("wr_iss_d1",    iss_data_1,        32'd10);
        checkOutput("wr_iss_d2",    iss_data_2,        32'd20);
        checkOutput("wr_iss_rob",   32'(iss_rob_addr), 32'd3);
        checkOutput("wr_count",     32'(count),        32'd1);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        checkOutput("iss_count0",   32'(count),        32'd0);
        checkOutput("iss_valid0",   32'(iss_valid),    32'd0);

        // Wakeup of operand 1 from CDB port 1, two cycles after dispatch
        applyStimulus(4'd4, 6'd2, 5'd3, 2'b01, 32'd7, 32'd33);
        pushExp(4'd4, 6'd2, 5'd3, 32'hDEAD, 32'd33);
        tick();
        idle();
        checkOutput("wk_wait1",     32'(iss_valid),    32'd0);
        checkOutput("wk_count",     32'(count),        32'd1);
        tick();
        checkOutput("wk_wait2",     32'(iss_valid),    32'd0);
        setCdb(0, 4'd6, 32'hBEEF);
        setCdb(1, 4'd7, 32'hDEAD);
        tick();
        idle();
        checkOutput("wk_iss_valid", 32'(iss_valid),    32'd1);
        checkOutput("wk_iss_d1",    iss_data_1,        32'hDEAD);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        checkOutput("wk_count0",    32'(count),        32'd0);
        checkOutput("hold_d1",      iss_data_1,        32'hDEAD);

        // Write bypass; both ports carry the tag, port 0 must win
        applyStimulus(4'd5, 6'd9, 5'd2, 2'b10, 32'd11, 32'd2);
        setCdb(0, 4'd2, 32'd55);
        setCdb(1, 4'd2, 32'd99);
        pushExp(4'd5, 6'd9, 5'd2, 32'd11, 32'd55);
        tick();
        idle();
        checkOutput("byp_iss_valid", 32'(iss_valid),   32'd1);
        checkOutput("byp_iss_d2",    iss_data_2,       32'd55);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;

        // Fill all lines waiting on tag 9, then drain in index order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(8 + i), 6'(i + 1), 5'(i), 2'b01, 32'd9, 32'(100 + i));
            pushExp(4'(8 + i), 6'(i + 1), 5'(i), 32'h1234, 32'(100 + i));
            tick();
        end
        idle();
        checkOutput("full_count",     32'(count),     32'd4);
        checkOutput("full_wr_ready",  32'(wr_ready),  32'd0);
        checkOutput("full_iss_valid", 32'(iss_valid), 32'd0);
        setCdb(0, 4'd9, 32'h1234);
        setCdb(1, 4'd9, 32'h5678);
        tick();
        idle();
        checkOutput("full_wake_rob",  32'(iss_rob_addr), 32'd8);
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("drain_count", 32'(count), 32'(3 - i));
        end
        iss_ready = 1'b0;

        // Write offered while full and issuing: refused now, lands in slot 0 next cycle
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'(i), 6'(10 + i), 5'(i), 2'b00, 32'(200 + i), 32'(300 + i));
            tick();
        end
        pushExp(4'd0, 6'd10, 5'd0, 32'd200, 32'd300);
        applyStimulus(4'd13, 6'd20, 5'd7, 2'b00, 32'd400, 32'd500);
        iss_ready = 1'b1;
        tick();
        iss_ready = 1'b0;
        checkOutput("fw_count",    32'(count),    32'd3);
        checkOutput("fw_wr_ready", 32'(wr_ready), 32'd1);
        tick();
        idle();
        checkOutput("fw_count4",   32'(count),        32'd4);
        checkOutput("fw_slot0",    32'(iss_rob_addr), 32'd13);
        pushExp(4'd13, 6'd20, 5'd7, 32'd400, 32'd500);
        for (int i = 1; i < 4; i++) begin
            pushExp(4'(i), 6'(10 + i), 5'(i), 32'(200 + i), 32'(300 + i));
        end
        iss_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        iss_ready = 1'b0;
        checkOutput("fw_drained",  32'(count), 32'd0);

        // Flush with three lines pending; the concurrent write is dropped
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'(i), 6'd1, 5'd0, 2'b11, 32'd15, 32'd15);
            tick();
        end
        applyStimulus(4'd14, 6'd3, 5'd3, 2'b00, 32'd1, 32'd2);
        flush = 1'b1;
        tick();
        idle();
        checkOutput("fl_count",     32'(count),     32'd0);
        checkOutput("fl_iss_valid", 32'(iss_valid), 32'd0);
        checkOutput("fl_wr_ready",  32'(wr_ready),  32'd1);
        setCdb(0, 4'd15, 32'h77);
        tick();
        idle();
        tick();
        checkOutput("fl_dropped",   32'(iss_valid), 32'd0);

        // Reset with ready lines present and a write offered
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'(6 + i), 6'd4, 5'd4, 2'b00, 32'(900 + i), 32'd1);
            tick();
        end
        idle();
        tick();
        checkOutput("pre_rst_count", 32'(count), 32'd3);
        applyStimulus(4'd15, 6'd2, 5'd2, 2'b00, 32'd5, 32'd6);
        rst = 1'b0;
        tick();
        idle();
        checkOutput("rst2_count",     32'(count),        32'd0);
        checkOutput("rst2_iss_valid", 32'(iss_valid),    32'd0);
        checkOutput("rst2_wr_ready",  32'(wr_ready),     32'd1);
        checkOutput("rst2_iss_rob",   32'(iss_rob_addr), 32'd0);
        checkOutput("rst2_iss_d1",    iss_data_1,        32'd0);
        checkOutput("rst2_iss_opgen", 32'(iss_opgen),    32'd0);
        rst = 1'b1;
        tick();
        checkOutput("rst2_after",     32'(iss_valid),    32'd0);

        tick();
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/rs_int_queue.md
# rs_int_queue

Parametrised integer reservation station holding `DEPTH` entries, with `CDB_PORTS` common-data-bus wakeup channels and a valid/ready handshake on both the dispatch and issue sides. It sits between the rename/dispatch stage and the integer ALU. Operand tags are snooped off the CDB until both operands are values, then the entry is issued and freed. It generalises the single-line integer RS: multiple lines, multiple CDBs, same-cycle write/CDB bypass, flush, and fixed-priority select.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; ≥2.
- `CDB_PORTS`, 2: number of CDB broadcast channels; ≥1.
- `ROB_ADDR_WIDTH`, 4: ROB index width, which is also the tag width.
- `OPGEN_WIDTH`, 6: operation-generator code width.
- `SHAMT_WIDTH`, 5: shift-amount width.
- `DATA_WIDTH`, 32: operand width.

Ports:
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-low.
- `flush  in  1`: discard all entries.
- `wr_valid  in  1`: dispatch request.
- `wr_ready  out  1`: station not full.
- `wr_rob_addr  in  ROB_ADDR_WIDTH`: destination ROB index.
- `wr_opgen  in  OPGEN_WIDTH`: operation code.
- `wr_shamt  in  SHAMT_WIDTH`: shift amount.
- `wr_is_ref  in  2`: bit i set means operand i is a tag, not a value.
- `wr_data_1`, `wr_data_2  in  DATA_WIDTH each`: operand value, or tag in the low `ROB_ADDR_WIDTH` bits.
- `cdb_en  in  CDB_PORTS`: per-port broadcast valid.
- `cdb_tag  in  CDB_PORTS*ROB_ADDR_WIDTH`: flattened; port p is at `[p*W +: W]`.
- `cdb_data  in  CDB_PORTS*DATA_WIDTH`: flattened, same layout.
- `iss_valid  out  1`: a ready entry is presented.
- `iss_ready  in  1`: ALU accepts.
- `iss_rob_addr`, `iss_opgen`, `iss_shamt`, `iss_data_1`, `iss_data_2  out  matching widths`: selected entry's fields.
- `count  out  $clog2(DEPTH+1)`: number of occupied entries.

## Operation
- Each entry holds `valid`, `rob_addr`, `opgen`, `shamt`, `is_ref[1:0]`, and `data_1/2`.
- An entry is ready when `valid && !is_ref[0] && !is_ref[1]`.
- **Allocation:**
  - `wr_ready = (count != DEPTH)`, computed from registered state only.
  - A handshake writes the lowest-index invalid entry.
- **Write bypass:** if an incoming operand is a ref and any enabled CDB port tag equals its tag in the same cycle, store `cdb_data` with `is_ref=0`.
- **Wakeup:**
  - Every valid entry compares each ref operand's low `ROB_ADDR_WIDTH` bits against every enabled CDB port.
  - On a match, it captures the data and clears `is_ref`.
  - Both operands may wake in the same cycle, from different or the same port.
  - If several ports match one operand, the lowest port index wins.
- **Select:**
  - `iss_valid` is set when any entry is ready.
  - Outputs show the lowest-index ready entry, as a combinational mux of registered state.
  - Outputs hold when `iss_valid=0`.
- **Issue:** `iss_valid && iss_ready` clears the selected entry's `valid` at the edge.
- Issue, write, and wakeup may all occur in one cycle.
  - A slot freed by issue is not reusable until the next cycle.
  - A wakeup does not make an entry issuable until the following cycle.
- **Flush:** clears all `valid` bits at the edge and overrides write and issue in that cycle. Field contents are don't-care.
- **Reset:** `rst=0` clears all entry fields to 0.
- **Reset values of outputs:**
  - `wr_ready=1`, `iss_valid=0`, `count=0`.
  - All `iss_*` data outputs are 0.
- Reset has priority over flush, and flush has priority over everything else.

## Timing
- Write accepted at edge N: the entry is visible from cycle N+1. If both operands are values or bypassed, `iss_valid=1` in N+1.
- CDB match at edge N: operand is a value from N+1, with the earliest issue in N+1.
- Issue handshake at edge N: entry invalid from N+1, and `count` decrements in N+1.
- `count` update: +1 on write, −1 on issue. A simultaneous write and issue leaves it unchanged.
- Full boundary: at `count==DEPTH` with an issue in progress, `wr_ready` stays 0 that cycle.
- No combinational path from `iss_ready` or `wr_valid` to `wr_ready` or `iss_valid`.

## Structure
- Shared package `rs_pkg` holds:
  - the width defaults: ROB addr, opgen, shamt, data;
  - an `rs_entry_t` struct of the entry fields;
  - a `TAG_MATCH` helper function.
- Sub-module `rs_int_entry` holds one entry's storage, wakeup compare across `CDB_PORTS`, write bypass, and the ready flag. It is instantiated `DEPTH` times.
- The top level holds:
  - the lowest-free allocator;
  - the lowest-ready select mux;
  - the count register;
  - flush/reset gating.

## Test plan
- **Reset, write, issue:** reset, then write `{rob=3, opgen=5, data 10/20, no refs}` → next cycle `iss_valid=1` with `iss_data_1=10`, `iss_data_2=20`, `iss_rob_addr=3`. `iss_ready=1` → `count` returns to 0.
- **Wakeup:** write `op1` ref tag 7. CDB port 1 broadcasts `{7, 0xDEAD}` two cycles later → `iss_valid` asserts the cycle after, with `iss_data_1=0xDEAD`. `iss_valid` stays 0 before that.
- **Write bypass:** write `op2` ref tag 2 while CDB port 0 broadcasts `{2, 55}` the same cycle → entry ready next cycle, `iss_data_2=55`.
- **Full:** fill 4 entries all waiting on tag 9 → `wr_ready=0`, `count=4`. Broadcast tag 9 → all four issue in index order 0..3 over 4 cycles with `iss_ready` held high.
- **Simultaneous write + issue when full:** at `count=4` with one entry ready, `iss_ready=1` and `wr_valid=1` → write not accepted this cycle, accepted next cycle into slot 0.
- **Flush/reset mid-operation:** with 3 entries pending, assert `flush` alongside `wr_valid` → `count=0` and `iss_valid=0` next cycle, and the write is dropped. Repeat with `rst=0` → all outputs at reset values.
